mpu_store_stream: RTL and testbench
===================================

MPU_STORE_STREAM -- requirements
Module: mpu_store_stream

Interface
REQ-001 Parameters SHALL be: FP, default 32, element width in bits; M, default global_defs M, maximum rows; N, default global_defs N, maximum columns; MBITS/NBITS, default global_defs, row/column index widths; MATRIX_REG_SIZE, default global_defs, register-address width.
REQ-002 Ports SHALL be as follows; the design uses one clock, and reset is synchronous and active-high:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  start pulse.
- store_addr  in  MATRIX_REG_SIZE  source register.
- matrix_m_size  in  MBITS+1  rows to emit.
- matrix_n_size  in  NBITS+1  columns to emit.
- reg_store_en  out  1  register-file read request.
- reg_store_addr  out  MATRIX_REG_SIZE  register-file read address.
- reg_element_in  in  FP x [M][N]  register-file matrix contents.
- reg_store_complete  in  1  register-file data valid.
- element_out  out  FP  streamed element.
- m_out  out  MBITS+1  row index of element_out.
- n_out  out  NBITS+1  column index of element_out.
- valid_out  out  1  element_out is valid.
- ready_in  in  1  downstream accept.
- last_out  out  1  final element of the matrix.
- busy  out  1  block is not in IDLE.
- ack  out  1  one-cycle pulse on completion.
- error  out  1  one-cycle pulse on bad size or timeout.

Function
REQ-003 The state machine SHALL have states IDLE, REQ, WAIT, STREAM and DONE, encoded as the package enum store_state_t.
REQ-004 In IDLE with en=1, the block SHALL check the requested sizes:
- If 1<=matrix_m_size<=M and 1<=matrix_n_size<=N, it SHALL latch store_addr and both sizes, then go to REQ.
- Otherwise it SHALL pulse error for one cycle and remain in IDLE.
REQ-005 In REQ, reg_store_en SHALL be 1 for exactly one cycle, with reg_store_addr equal to the latched address; the next state SHALL be WAIT.
REQ-006 In WAIT, on reg_store_complete=1 the block SHALL capture reg_element_in into a local M x N buffer in that cycle, clear the row/column indices, and go to STREAM.
REQ-007 If WAIT lasts STORE_TIMEOUT (16) cycles without reg_store_complete, the block SHALL pulse error for one cycle and go to IDLE.
REQ-008 In STREAM, valid_out SHALL be 1 and element_out SHALL equal buffer[m_out][n_out]. Emission order SHALL be row-major, starting at (0,0).
REQ-009 The indices SHALL advance only on a cycle where valid_out and ready_in are both 1:
- n increments each handshake.
- When n equals size_n-1, n SHALL wrap to 0 and m SHALL increment.
REQ-010 While valid_out=1 and ready_in=0, element_out, m_out, n_out and last_out SHALL hold stable.
REQ-011 last_out SHALL be 1 only while the final element (m=size_m-1, n=size_n-1) is presented; the handshake on that element SHALL move the block to DONE.
REQ-012 In DONE, ack SHALL be 1 for one cycle, after which the block SHALL return to IDLE.
REQ-013 busy SHALL be 1 in every state other than IDLE.
REQ-014 en SHALL be ignored in every state other than IDLE.
REQ-015 Minimum latency from en to the first valid_out SHALL be 3 cycles, given reg_store_complete=1 on the first WAIT cycle.
REQ-016 A 1x1 matrix SHALL assert last_out on its first and only valid cycle.

Reset
REQ-017 On rst=1 at a clock edge, the block SHALL enter IDLE and drive all outputs to 0, including while mid-operation.
REQ-018 Reset SHALL clear the indices and latched sizes; the buffer contents need not be cleared.

Configuration
REQ-019 Column-major output SHALL be controlled by the macro MPU_STORE_TRANSPOSE_EN:
- When defined, the block SHALL have an added input port transpose (1 bit), latched at start. When transpose is 1, emission order SHALL be column-major: m increments per handshake and wraps to 0 at size_m-1, then n increments. m_out and n_out SHALL still report source coordinates.
- When not defined, the transpose port SHALL be absent and the order SHALL always be row-major.

Structure
REQ-020 The enum store_state_t and the constant STORE_TIMEOUT SHALL live in mpu_pkg; FP, M, N, MBITS, NBITS and MATRIX_REG_SIZE SHALL come from global_defs.
REQ-021 The row/column walk, including wrap and the transpose ordering, SHALL be a single sub-module, mpu_store_index_counter.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- 2x2 matrix {3f800000, 424951ec, c0200000, 3e000000}, ready_in=1 throughout -> those four words in that order, with indices (0,0), (0,1), (1,0), (1,1); last_out on the 4th; ack one cycle later.
- Same matrix with ready_in toggling 1,0,0,1,... -> no element dropped or duplicated, and outputs stable during every stall.
- en with matrix_m_size=0 or matrix_n_size=N+1 -> error pulse, no reg_store_en, busy stays 0.
- reg_store_complete held at 0 -> error at the 16th WAIT cycle, then IDLE.
- rst asserted after the 2nd handshake of a 2x2 -> next cycle all outputs are 0 and busy=0; a fresh en then streams from (0,0).
- With MPU_STORE_TRANSPOSE_EN defined and transpose=1 on the 2x2 -> order 3f800000, c0200000, 424951ec, 3e000000.

Source files
------------

// File: rtl/global_defs.sv
// Project-wide matrix geometry shared by all MPU blocks.
package global_defs;
  localparam int FP              = 32;
  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MBITS           = 2;
  localparam int NBITS           = 2;
  localparam int MATRIX_REG_SIZE = 4;
endpackage

// File: rtl/mpu_pkg.sv
// MPU store-stream types: FSM state enum, WAIT timeout and the latched job descriptor.
package mpu_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, STREAM, DONE} store_state_t;

  localparam int STORE_TIMEOUT = 16;

  typedef struct packed {
    logic [global_defs::MATRIX_REG_SIZE-1:0] addr;
    logic [global_defs::MBITS:0]             size_m;
    logic [global_defs::NBITS:0]             size_n;
    logic                                    transpose;
  } store_cfg_t;
endpackage

// File: rtl/mpu_store_stream_if.sv
// Element stream from mpu_store_stream to its consumer (valid/ready handshake).
interface mpu_store_stream_if #(
  parameter int FP    = global_defs::FP,
  parameter int MBITS = global_defs::MBITS,
  parameter int NBITS = global_defs::NBITS
);
  logic [FP-1:0]  element_out;
  logic [MBITS:0] m_out;
  logic [NBITS:0] n_out;
  logic           valid_out;
  logic           ready_in;
  logic           last_out;

  modport master (output element_out, m_out, n_out, valid_out, last_out, input ready_in);
  modport slave  (input element_out, m_out, n_out, valid_out, last_out, output ready_in);
endinterface

// File: rtl/mpu_store_index_counter.sv
// Row/column walk over a size_m x size_n matrix; row-major, or column-major when transpose=1.
module mpu_store_index_counter #(
  parameter int MBITS = global_defs::MBITS,
  parameter int NBITS = global_defs::NBITS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           adv,
  input  logic           transpose,
  input  logic [MBITS:0] size_m,
  input  logic [NBITS:0] size_n,
  output logic [MBITS:0] m,
  output logic [NBITS:0] n,
  output logic           last
);
  localparam logic [MBITS:0] M_ONE = 1;
  localparam logic [NBITS:0] N_ONE = 1;

  logic m_end, n_end;
  assign m_end = (m == size_m - M_ONE);
  assign n_end = (n == size_n - N_ONE);
  assign last  = m_end && n_end;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      m <= '0;
      n <= '0;
    end else if (adv) begin
      if (transpose) begin
        if (m_end) begin
          m <= '0;
          n <= n + N_ONE;
        end else begin
          m <= m + M_ONE;
        end
      end else begin
        if (n_end) begin
          n <= '0;
          m <= m + M_ONE;
        end else begin
          n <= n + N_ONE;
        end
      end
    end
  end
endmodule

// File: rtl/mpu_store_stream.sv
// Reads one matrix from the register file and streams it element by element.
// Build option: MPU_STORE_TRANSPOSE_EN adds a transpose input for column-major order.
module mpu_store_stream
  import mpu_pkg::*;
#(
  parameter int FP              = global_defs::FP,
  parameter int M               = global_defs::M,
  parameter int N               = global_defs::N,
  parameter int MBITS           = global_defs::MBITS,
  parameter int NBITS           = global_defs::NBITS,
  parameter int MATRIX_REG_SIZE = global_defs::MATRIX_REG_SIZE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [MATRIX_REG_SIZE-1:0]       store_addr,
  input  logic [MBITS:0]                   matrix_m_size,
  input  logic [NBITS:0]                   matrix_n_size,
`ifdef MPU_STORE_TRANSPOSE_EN
  input  logic                             transpose,
`endif
  output logic                             reg_store_en,
  output logic [MATRIX_REG_SIZE-1:0]       reg_store_addr,
  input  logic [M-1:0][N-1:0][FP-1:0]      reg_element_in,
  input  logic                             reg_store_complete,
  mpu_store_stream_if.master               so,
  output logic                             busy,
  output logic                             ack,
  output logic                             error
);
  localparam int WCW = $clog2(STORE_TIMEOUT) + 1;

  store_state_t                 state, nxt;
  store_cfg_t                   cfg_q;
  logic [WCW-1:0]               wait_cnt;
  logic [M-1:0][N-1:0][FP-1:0]  buf_q;
  logic [MBITS:0]               m_idx;
  logic [NBITS:0]               n_idx;
  logic                         idx_last, size_ok, timeout, tr_in;

`ifdef MPU_STORE_TRANSPOSE_EN
  assign tr_in = transpose;
`else
  assign tr_in = 1'b0;
`endif

  assign size_ok = (matrix_m_size != '0) && (matrix_m_size <= (MBITS+1)'(M)) &&
                   (matrix_n_size != '0) && (matrix_n_size <= (NBITS+1)'(N));
  assign timeout = !reg_store_complete && (wait_cnt == WCW'(STORE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt            = state;
    reg_store_en   = 1'b0;
    reg_store_addr = '0;
    so.valid_out   = 1'b0;
    so.element_out = '0;
    so.m_out       = '0;
    so.n_out       = '0;
    so.last_out    = 1'b0;
    busy           = (state != IDLE);
    ack            = 1'b0;
    error          = 1'b0;
    case (state)
      IDLE: if (en) begin
        if (size_ok) nxt = REQ;
        else         error = 1'b1;
      end
      REQ: begin
        reg_store_en   = 1'b1;
        reg_store_addr = cfg_q.addr;
        nxt            = WAIT;
      end
      WAIT: begin
        if (reg_store_complete) nxt = STREAM;
        else if (timeout) begin
          error = 1'b1;
          nxt   = IDLE;
        end
      end
      STREAM: begin
        so.valid_out   = 1'b1;
        so.element_out = buf_q[m_idx[MBITS-1:0]][n_idx[NBITS-1:0]];
        so.m_out       = m_idx;
        so.n_out       = n_idx;
        so.last_out    = idx_last;
        if (so.ready_in && idx_last) nxt = DONE;
      end
      DONE: begin
        ack = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q    <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == IDLE && en && size_ok)
        cfg_q <= '{addr: store_addr, size_m: matrix_m_size, size_n: matrix_n_size, transpose: tr_in};
      if (state == REQ)       wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  // Snapshot is unreset: it is always rewritten before STREAM can read it.
  always_ff @(posedge clk) begin
    if (state == WAIT && reg_store_complete) buf_q <= reg_element_in;
  end

  mpu_store_index_counter #(.MBITS(MBITS), .NBITS(NBITS)) u_idx (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == WAIT && reg_store_complete),
    .adv       (state == STREAM && so.ready_in),
    .transpose (cfg_q.transpose),
    .size_m    (cfg_q.size_m),
    .size_n    (cfg_q.size_n),
    .m         (m_idx),
    .n         (n_idx),
    .last      (idx_last)
  );
endmodule

// File: tb/tb_mpu_store_stream.sv
// Directed and randomized bench for mpu_store_stream against a queue-based order model.
module tb_mpu_store_stream;
  import global_defs::*;

`ifdef MPU_STORE_TRANSPOSE_EN
  localparam bit HAS_TR = 1'b1;
`else
  localparam bit HAS_TR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst, en;
  logic [MATRIX_REG_SIZE-1:0]  store_addr;
  logic [MBITS:0]              msz;
  logic [NBITS:0]              nsz;
`ifdef MPU_STORE_TRANSPOSE_EN
  logic                        transpose;
`endif
  logic                        reg_store_en;
  logic [MATRIX_REG_SIZE-1:0]  reg_store_addr;
  logic [M-1:0][N-1:0][FP-1:0] reg_element_in;
  logic                        reg_store_complete;
  logic                        busy, ack, error;

  mpu_store_stream_if sif ();

  mpu_store_stream dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .store_addr         (store_addr),
    .matrix_m_size      (msz),
    .matrix_n_size      (nsz),
`ifdef MPU_STORE_TRANSPOSE_EN
    .transpose          (transpose),
`endif
    .reg_store_en       (reg_store_en),
    .reg_store_addr     (reg_store_addr),
    .reg_element_in     (reg_element_in),
    .reg_store_complete (reg_store_complete),
    .so                 (sif),
    .busy               (busy),
    .ack                (ack),
    .error              (error)
  );

  int passed = 0, total = 0, fails = 0;
  logic [FP-1:0] mat [M][N];
  typedef struct { int m; int n; logic [FP-1:0] v; } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected emission sequence straight from the ordering rule.
  function automatic void build(input int sm, input int sn, input bit tr);
    q.delete();
    if (tr) begin
      for (int j = 0; j < sn; j++)
        for (int i = 0; i < sm; i++) q.push_back('{i, j, mat[i][j]});
    end else begin
      for (int i = 0; i < sm; i++)
        for (int j = 0; j < sn; j++) q.push_back('{i, j, mat[i][j]});
    end
  endfunction

  task automatic randomize_mat;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) mat[i][j] = $urandom;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, sif.valid_out, 0);
    chk({tag, "_elem"},  sif.element_out, 0);
    chk({tag, "_m"},     sif.m_out, 0);
    chk({tag, "_n"},     sif.n_out, 0);
    chk({tag, "_last"},  sif.last_out, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_ack"},   ack, 0);
    chk({tag, "_err"},   error, 0);
    chk({tag, "_ren"},   reg_store_en, 0);
    chk({tag, "_raddr"}, reg_store_addr, 0);
  endtask

  // mode: 0 ready always, 1 ready 1,0,0 repeating, 2 random. rst_at>=0 resets once that many handshakes are done.
  task automatic run(input int sm, input int sn, input bit tr, input int mode, input int rst_at);
    logic [MATRIX_REG_SIZE-1:0] a;
    int  idx, cyc;
    bit  rdy;
    a = MATRIX_REG_SIZE'($urandom);
    build(sm, sn, tr);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) reg_element_in[i][j] = mat[i][j];
    en = 1'b1; store_addr = a; msz = (MBITS+1)'(sm); nsz = (NBITS+1)'(sn);
`ifdef MPU_STORE_TRANSPOSE_EN
    transpose = tr;
`endif
    tick;
    en = 1'b0; store_addr = ~a;
    chk("req_en", reg_store_en, 1);
    chk("req_addr", reg_store_addr, a);
    chk("req_busy", busy, 1);
    reg_store_complete = 1'b1;
    tick;
    chk("wait_valid", sif.valid_out, 0);
    chk("wait_ren", reg_store_en, 0);
    tick;
    reg_store_complete = 1'b0;
    idx = 0; cyc = 0;
    while (idx < q.size() && cyc < 400) begin
      if (rst_at >= 0 && idx == rst_at) begin
        rst = 1'b1; sif.ready_in = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      sif.ready_in = rdy;
      #1;
      chk("valid", sif.valid_out, 1);
      chk("elem",  sif.element_out, q[idx].v);
      chk("m_out", sif.m_out, q[idx].m);
      chk("n_out", sif.n_out, q[idx].n);
      chk("last",  sif.last_out, idx == q.size() - 1);
      chk("ack_streaming", ack, 0);
      if (rdy) idx++;
      cyc++;
      tick;
    end
    sif.ready_in = 1'b0;
    chk("stream_len", idx, q.size());
    chk("done_ack", ack, 1);
    chk("done_valid", sif.valid_out, 0);
    chk("done_busy", busy, 1);
    tick;
    chk("post_ack", ack, 0);
    chk("post_busy", busy, 0);
  endtask

  task automatic bad_size(input int sm, input int sn, input string tag);
    en = 1'b1; msz = (MBITS+1)'(sm); nsz = (NBITS+1)'(sn); store_addr = '1;
    #1;
    chk({tag, "_err"}, error, 1);
    chk({tag, "_busy"}, busy, 0);
    tick;
    en = 1'b0;
    #1;
    chk({tag, "_err_after"}, error, 0);
    chk({tag, "_ren"}, reg_store_en, 0);
    chk({tag, "_busy_after"}, busy, 0);
    tick;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; store_addr = '0; msz = '0; nsz = '0;
`ifdef MPU_STORE_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    reg_element_in = '0; reg_store_complete = 1'b0; sif.ready_in = 1'b0;
    tick; tick;
    check_idle_outputs("reset");
    rst = 1'b0;
    tick;

    randomize_mat();
    mat[0][0] = 32'h3f800000; mat[0][1] = 32'h424951ec;
    mat[1][0] = 32'hc0200000; mat[1][1] = 32'h3e000000;
    run(2, 2, 1'b0, 0, -1);
    run(2, 2, 1'b0, 1, -1);
`ifdef MPU_STORE_TRANSPOSE_EN
    run(2, 2, 1'b1, 0, -1);
`endif

    bad_size(0, 2, "m_zero");
    bad_size(2, N + 1, "n_over");
    bad_size(M + 1, 1, "m_over");

    // Register file never answers: error on the 16th WAIT cycle.
    en = 1'b1; msz = 2; nsz = 2; store_addr = 4'h5;
    tick;
    en = 1'b0;
    tick;
    for (int k = 1; k < 16; k++) begin
      chk("wait_noerr", error, 0);
      chk("wait_busy", busy, 1);
      tick;
    end
    chk("timeout_err", error, 1);
    tick;
    chk("timeout_idle", busy, 0);
    chk("timeout_err_clr", error, 0);

    run(2, 2, 1'b0, 0, 2);
    tick;
    run(2, 2, 1'b0, 0, -1);

    run(1, 1, 1'b0, 0, -1);
    randomize_mat();
    run(M, N, 1'b0, 1, -1);
    for (int t = 0; t < 12; t++) begin
      randomize_mat();
      run($urandom_range(1, M), $urandom_range(1, N), HAS_TR & 1'($urandom), 2, -1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
